// File: rtl/countdown_bcd_timer.sv
// Two-digit BCD countdown timer: loads a binary duration (clamped to 99), counts
// down once per TICK_DIV clock cycles and pulses done on reaching 00.
//
//   state | meaning
//   IDLE  | not counting; digits hold last value (dash after reset, 00 after expiry)
//   RUN   | counting down, one decrement per prescaler tick
module countdown_bcd_timer #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0] DASH = 4'hA;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          tick;

    logic [6:0] clamped;
    logic [6:0] r80;
    logic [5:0] r40;
    logic [4:0] r20;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;

    assign clamped = (load_val > 7'd99) ? 7'd99 : load_val;

    // Restoring subtract chain: tens = 8/4/2/1 multiples of ten taken in turn.
    assign bcd_tens[3] = (clamped >= 7'd80);
    assign r80         = bcd_tens[3] ? (clamped - 7'd80) : clamped;
    assign bcd_tens[2] = (r80 >= 7'd40);
    assign r40         = bcd_tens[2] ? 6'(r80 - 7'd40) : 6'(r80);
    assign bcd_tens[1] = (r40 >= 6'd20);
    assign r20         = bcd_tens[1] ? 5'(r40 - 6'd20) : 5'(r40);
    assign bcd_tens[0] = (r20 >= 5'd10);
    assign bcd_ones    = bcd_tens[0] ? 4'(r20 - 5'd10) : 4'(r20);

    assign tick = (prescaler == PS_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            tens      <= DASH;
            ones      <= DASH;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                prescaler <= '0;
                tens      <= bcd_tens;
                ones      <= bcd_ones;
                if (clamped == 7'd0) begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: prescaler <= '0;
                    RUN: begin
                        if (!pause) begin
                            if (tick) begin
                                prescaler <= '0;
                                if (ones != 4'd0) begin
                                    ones <= ones - 4'd1;
                                end else begin
                                    ones <= 4'd9;
                                    tens <= tens - 4'd1;
                                end
                                // 01 -> 00 ends the phase in the same cycle.
                                if (tens == 4'd0 && ones == 4'd1) begin
                                    state   <= IDLE;
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                end
                            end else begin
                                prescaler <= prescaler + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// Scoreboard bench for countdown_bcd_timer (TICK_DIV=4): stimulus queues the
// expected output changes with their cycle stamps, a negedge monitor checks them.
module tb_countdown_bcd_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [6:0] load_val;
    logic       pause;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;

    countdown_bcd_timer #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .pause    (pause),
        .tens     (tens),
        .ones     (ones),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       r;
        logic       d;
        int         c;
    } ev_t;

    ev_t  q[$];
    int   tests = 0;
    int   fails = 0;
    int   ev_idx = 0;
    bit   mon_en = 0;
    logic [9:0] prev;

    task automatic push(input logic [3:0] t, input logic [3:0] o,
                        input logic r, input logic d, input int c);
        ev_t e;
        e.t = t; e.o = o; e.r = r; e.d = d; e.c = c;
        q.push_back(e);
    endtask

    task automatic pulse(input logic [6:0] v);
        load_val = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic [3:0] got, input logic [3:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: any change of the visible outputs is an event that must match the queue head.
    always @(negedge clk) begin
        logic [9:0] cur;
        ev_t e;
        if (mon_en) begin
            cur = {tens, ones, running, done};
            if (cur !== prev) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got %h/%h run=%b done=%b @%0d, want no change",
                             tens, ones, running, done, cyc);
                end else begin
                    e = q.pop_front();
                    if (tens !== e.t || ones !== e.o || running !== e.r ||
                        done !== e.d || cyc != e.c) begin
                        fails++;
                        $display("FAIL ev%0d: got %h/%h run=%b done=%b @%0d, want %h/%h run=%b done=%b @%0d",
                                 ev_idx, tens, ones, running, done, cyc,
                                 e.t, e.o, e.r, e.d, e.c);
                    end
                end
                ev_idx++;
            end
            prev = cur;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        rst = 1'b1; load = 1'b0; load_val = '0; pause = 1'b0;
        repeat (2) @(negedge clk);
        check_now("rst_tens", tens, 4'hA);
        check_now("rst_ones", ones, 4'hA);
        check_now("rst_running", {3'b0, running}, 4'h0);
        check_now("rst_done", {3'b0, done}, 4'h0);
        rst = 1'b0;
        prev = {tens, ones, running, done};
        mon_en = 1;
        repeat (3) @(negedge clk);

        // Countdown from 12 with a decrement every 4 cycles.
        l = cyc;
        push(4'd1, 4'd2, 1'b1, 1'b0, l + 1);
        for (int v = 11; v >= 1; v--)
            push(4'(v / 10), 4'(v % 10), 1'b1, 1'b0, l + 1 + 4 * (12 - v));
        push(4'd0, 4'd0, 1'b0, 1'b1, l + 49);
        push(4'd0, 4'd0, 1'b0, 1'b0, l + 50);
        pulse(7'd12);
        wait_until(l + 53);

        // Zero load from IDLE: immediate done, running stays low.
        l = cyc;
        push(4'd0, 4'd0, 1'b0, 1'b1, l + 1);
        push(4'd0, 4'd0, 1'b0, 1'b0, l + 2);
        pulse(7'd0);
        wait_until(l + 3);

        // Clamp 120 -> 99.
        l = cyc;
        push(4'd9, 4'd9, 1'b1, 1'b0, l + 1);
        pulse(7'd120);

        // Reload 5 mid-run, then pause 10 cycles with prescaler at 2.
        l = cyc;
        push(4'd0, 4'd5, 1'b1, 1'b0, l + 1);
        pulse(7'd5);
        wait_until(l + 3);
        pause = 1'b1;
        push(4'd0, 4'd4, 1'b1, 1'b0, l + 15);
        push(4'd0, 4'd3, 1'b1, 1'b0, l + 19);
        wait_until(l + 13);
        pause = 1'b0;
        wait_until(l + 20);

        // Load 30 on the tick cycle while at 0/7: no decrement, prescaler restarts.
        l = cyc;
        push(4'd0, 4'd8, 1'b1, 1'b0, l + 1);
        push(4'd0, 4'd7, 1'b1, 1'b0, l + 5);
        pulse(7'd8);
        wait_until(l + 8);
        push(4'd3, 4'd0, 1'b1, 1'b0, l + 9);
        push(4'd2, 4'd9, 1'b1, 1'b0, l + 13);
        pulse(7'd30);
        wait_until(l + 14);

        // Reset mid-run at 0/4: dashes, no done pulse afterwards.
        l = cyc;
        push(4'd0, 4'd5, 1'b1, 1'b0, l + 1);
        push(4'd0, 4'd4, 1'b1, 1'b0, l + 5);
        pulse(7'd5);
        wait_until(l + 6);
        push(4'hA, 4'hA, 1'b0, 1'b0, l + 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_until(l + 25);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: got %0d left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
